// File: rtl/pe_net_iface.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pe_net_iface : PE-side endpoint of a bufferless XY mesh switch port.     |
// |   RX: address check + FWFT payload FIFO; TX: result fan-out to a list.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pe_net_iface #(
  parameter int X_COORD     = 1,
  parameter int Y_COORD     = 2,
  parameter int X_SIZE      = 2,
  parameter int Y_SIZE      = 2,
  parameter int DATA_WIDTH  = 8,
  parameter int TOTAL_WIDTH = 2*X_SIZE + 2*Y_SIZE + DATA_WIDTH,
  parameter int NUM_DEST    = 4,
  parameter logic [NUM_DEST*(X_SIZE+Y_SIZE)-1:0] DEST_LIST = '0,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_valid_net,
  input  logic [TOTAL_WIDTH-1:0]   i_data_net,
  output logic                     o_ready_net,
  output logic                     o_valid_net,
  output logic [TOTAL_WIDTH-1:0]   o_data_net,
  input  logic                     i_ready_net,
  output logic                     o_valid_nrn,
  output logic [DATA_WIDTH-1:0]    o_data_nrn,
  output logic [X_SIZE+Y_SIZE-1:0] o_src_nrn,
  input  logic                     i_ready_nrn,
  input  logic                     i_valid_nrn,
  input  logic [DATA_WIDTH-1:0]    i_data_nrn,
  output logic                     o_ready_nrn,
  output logic                     o_busy,
  output logic [7:0]               o_drop_cnt
);

  localparam int c_coord_w = X_SIZE + Y_SIZE;
  localparam int c_ptr_w   = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w   = c_ptr_w + 1;
  localparam int c_idx_w   = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;
  localparam int c_entry_w = c_coord_w + DATA_WIDTH;

  localparam logic [c_coord_w-1:0] c_own  = {X_SIZE'(X_COORD), Y_SIZE'(Y_COORD)};
  localparam logic [c_cnt_w-1:0]   c_full = c_cnt_w'(FIFO_DEPTH);
  localparam logic [c_idx_w-1:0]   c_last = c_idx_w'(NUM_DEST - 1);

  // ---------------- receive path ----------------
  logic [c_coord_w-1:0]  w_rx_dst;
  logic [c_coord_w-1:0]  w_rx_src;
  logic [DATA_WIDTH-1:0] w_rx_data;
  logic                  w_rx_fire;
  logic                  w_rx_match;
  logic                  w_push;
  logic                  w_pop;

  logic [c_entry_w-1:0] r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_cnt_w-1:0]   r_count;
  logic [7:0]           r_drop_cnt;

  assign w_rx_dst   = i_data_net[c_coord_w-1:0];
  assign w_rx_src   = i_data_net[2*c_coord_w-1:c_coord_w];
  assign w_rx_data  = i_data_net[TOTAL_WIDTH-1 -: DATA_WIDTH];
  assign w_rx_fire  = i_valid_net & o_ready_net;
  assign w_rx_match = (w_rx_dst == c_own);
  assign w_push     = w_rx_fire & w_rx_match;
  assign w_pop      = o_valid_nrn & i_ready_nrn;

  assign o_ready_net = (r_count != c_full);
  assign o_valid_nrn = (r_count != '0);
  assign {o_src_nrn, o_data_nrn} = r_mem[r_rd_ptr];
  assign o_drop_cnt  = r_drop_cnt;

  // Storage needs no reset: reads are gated by the count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_rx_src, w_rx_data};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
      if (w_rx_fire && !w_rx_match && (r_drop_cnt != 8'hFF))
        r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  // ---------------- transmit path ----------------
  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } tx_state_t;

  tx_state_t               r_state, w_state_nxt;
  logic [c_idx_w-1:0]      r_idx, w_idx_nxt;
  logic [DATA_WIDTH-1:0]   r_payload, w_payload_nxt;
  logic [TOTAL_WIDTH-1:0]  r_flit, w_flit_nxt;

  function automatic logic [c_coord_w-1:0] f_dest(input logic [c_idx_w-1:0] idx);
    return DEST_LIST[idx*c_coord_w +: c_coord_w];
  endfunction

  assign o_data_net = r_flit;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_payload <= '0;
      r_flit    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_payload <= w_payload_nxt;
      r_flit    <= w_flit_nxt;
    end
  end

  // Flit register is loaded one step ahead so o_valid_net/o_data_net are
  // purely registered; i_ready_net only steers the next-state choice.
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_payload_nxt = r_payload;
    w_flit_nxt    = r_flit;
    o_ready_nrn   = 1'b0;
    o_valid_net   = 1'b0;
    o_busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_ready_nrn = 1'b1;
        if (i_valid_nrn) begin
          w_payload_nxt = i_data_nrn;
          w_idx_nxt     = '0;
          w_flit_nxt    = {i_data_nrn, c_own, f_dest('0)};
          w_state_nxt   = S_SEND;
        end
      end
      S_SEND: begin
        o_valid_net = 1'b1;
        o_busy      = 1'b1;
        if (i_ready_net) begin
          if (r_idx == c_last) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_idx_nxt  = r_idx + c_idx_w'(1);
            w_flit_nxt = {r_payload, c_own, f_dest(r_idx + c_idx_w'(1))};
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_pe_net_iface.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pe_net_iface : scoreboard bench for pe_net_iface (directed vectors).  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pe_net_iface;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_valid_net;
  logic [15:0] i_data_net;
  logic        o_ready_net;
  logic        o_valid_net;
  logic [15:0] o_data_net;
  logic        i_ready_net;
  logic        o_valid_nrn;
  logic [7:0]  o_data_nrn;
  logic [3:0]  o_src_nrn;
  logic        i_ready_nrn;
  logic        i_valid_nrn;
  logic [7:0]  i_data_nrn;
  logic        o_ready_nrn;
  logic        o_busy;
  logic [7:0]  o_drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] rx_exp [$];
  logic [15:0] tx_exp [$];

  // entries 0..3 = (2,2),(3,2),(1,3),(1,2)
  pe_net_iface #(.DEST_LIST(16'h67EA)) dut (
    .clk(clk), .rstn(rstn),
    .i_valid_net(i_valid_net), .i_data_net(i_data_net), .o_ready_net(o_ready_net),
    .o_valid_net(o_valid_net), .o_data_net(o_data_net), .i_ready_net(i_ready_net),
    .o_valid_nrn(o_valid_nrn), .o_data_nrn(o_data_nrn), .o_src_nrn(o_src_nrn),
    .i_ready_nrn(i_ready_nrn), .i_valid_nrn(i_valid_nrn), .i_data_nrn(i_data_nrn),
    .o_ready_nrn(o_ready_nrn), .o_busy(o_busy), .o_drop_cnt(o_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mk_flit(input logic [7:0] d, input logic [1:0] sx,
                                          input logic [1:0] sy, input logic [1:0] dx,
                                          input logic [1:0] dy);
    return {d, sx, sy, dx, dy};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_result(input logic [7:0] d);
    tx_exp.push_back(mk_flit(d, 2'd1, 2'd2, 2'd2, 2'd2));
    tx_exp.push_back(mk_flit(d, 2'd1, 2'd2, 2'd3, 2'd2));
    tx_exp.push_back(mk_flit(d, 2'd1, 2'd2, 2'd1, 2'd3));
    tx_exp.push_back(mk_flit(d, 2'd1, 2'd2, 2'd1, 2'd2));
  endtask

  task automatic wait_tx_done(input string name);
    int n;
    n = 0;
    while (!o_ready_nrn && n < 50) begin
      n++;
      cyc();
    end
    check(name, {31'd0, o_ready_nrn}, 32'd1);
  endtask

  // Monitor: sampled at negedge, where the inputs for the coming edge are settled.
  always @(negedge clk) begin
    if (rstn) begin
      if (o_valid_nrn && i_ready_nrn) begin
        if (rx_exp.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL rx_unexpected: got %0h expected none", {o_src_nrn, o_data_nrn});
        end else begin
          check("rx_payload", 32'({o_src_nrn, o_data_nrn}), 32'(rx_exp.pop_front()));
        end
      end
      if (o_valid_net) begin
        if (tx_exp.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL tx_unexpected: got %0h expected none", o_data_net);
        end else if (i_ready_net) begin
          check("tx_flit", 32'(o_data_net), 32'(tx_exp.pop_front()));
        end else begin
          check("tx_hold", 32'(o_data_net), 32'(tx_exp[0]));
        end
      end
    end
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    logic [7:0] pat;
    int n;
    rstn = 1'b0; i_valid_net = 1'b0; i_data_net = '0; i_ready_net = 1'b0;
    i_ready_nrn = 1'b0; i_valid_nrn = 1'b0; i_data_nrn = '0;
    repeat (3) cyc();
    check("rst_valid_net", {31'd0, o_valid_net}, 32'd0);
    check("rst_data_net",  32'(o_data_net), 32'd0);
    check("rst_valid_nrn", {31'd0, o_valid_nrn}, 32'd0);
    check("rst_ready_net", {31'd0, o_ready_net}, 32'd1);
    check("rst_ready_nrn", {31'd0, o_ready_nrn}, 32'd1);
    check("rst_busy",      {31'd0, o_busy}, 32'd0);
    check("rst_drop",      32'(o_drop_cnt), 32'd0);
    rstn = 1'b1;
    cyc();

    // Receive: first flit, then fill the FIFO, fifth held off.
    i_data_net = mk_flit(8'hA5, 2'd0, 2'd2, 2'd1, 2'd2);
    rx_exp.push_back({4'b0010, 8'hA5});
    i_valid_net = 1'b1;
    cyc();
    i_valid_net = 1'b0;
    check("rx_first_valid", {31'd0, o_valid_nrn}, 32'd1);
    check("rx_first_data",  32'(o_data_nrn), 32'hA5);
    check("rx_first_src",   32'(o_src_nrn), 32'h2);
    i_valid_net = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      i_data_net = mk_flit(8'hB0 + 8'(i), 2'(i), 2'd0, 2'd1, 2'd2);
      rx_exp.push_back({2'(i), 2'd0, 8'hB0 + 8'(i)});
      cyc();
    end
    i_data_net = mk_flit(8'hC5, 2'd3, 2'd3, 2'd1, 2'd2);
    rx_exp.push_back({4'b1111, 8'hC5});
    check("rx_full_ready", {31'd0, o_ready_net}, 32'd0);
    repeat (3) begin
      cyc();
      check("rx_full_hold", {31'd0, o_ready_net}, 32'd0);
    end
    i_ready_nrn = 1'b1;
    cyc();
    i_ready_nrn = 1'b0;
    check("rx_ready_after_pop", {31'd0, o_ready_net}, 32'd1);
    cyc();
    i_valid_net = 1'b0;
    check("rx_full_again", {31'd0, o_ready_net}, 32'd0);
    i_ready_nrn = 1'b1;
    repeat (5) cyc();
    i_ready_nrn = 1'b0;
    check("rx_drained_valid", {31'd0, o_valid_nrn}, 32'd0);
    check("rx_drained_queue", 32'(rx_exp.size()), 32'd0);

    // Misaddressed flits: single drop, then saturation.
    i_data_net = mk_flit(8'h11, 2'd0, 2'd0, 2'd3, 2'd3);
    i_valid_net = 1'b1;
    cyc();
    i_valid_net = 1'b0;
    check("drop_one", 32'(o_drop_cnt), 32'd1);
    check("drop_not_stored", {31'd0, o_valid_nrn}, 32'd0);
    i_valid_net = 1'b1;
    repeat (299) cyc();
    i_valid_net = 1'b0;
    check("drop_saturate", 32'(o_drop_cnt), 32'd255);

    // Transmit with ready held high.
    i_ready_net = 1'b1;
    i_data_nrn = 8'h3C;
    i_valid_nrn = 1'b1;
    push_result(8'h3C);
    cyc();
    i_valid_nrn = 1'b0;
    check("tx_busy", {31'd0, o_busy}, 32'd1);
    n = 0;
    while (!o_ready_nrn && n < 20) begin
      n++;
      cyc();
    end
    check("tx_ready_low_cycles", 32'(n), 32'd4);
    check("tx_valid_after", {31'd0, o_valid_net}, 32'd0);
    check("tx_queue_empty", 32'(tx_exp.size()), 32'd0);

    // Transmit with ready toggling 1,0,0,1,0,1,0,1.
    pat = 8'b1010_1001;
    i_data_nrn = 8'h5A;
    i_valid_nrn = 1'b1;
    push_result(8'h5A);
    cyc();
    i_valid_nrn = 1'b0;
    n = 0;
    while (!o_ready_nrn && n < 40) begin
      i_ready_net = pat[n % 8];
      n++;
      cyc();
    end
    check("tx_toggle_done", {31'd0, o_ready_nrn}, 32'd1);
    check("tx_toggle_queue", 32'(tx_exp.size()), 32'd0);
    i_ready_net = 1'b1;

    // Push+pop at count 2 while a transmit runs.
    i_valid_net = 1'b1;
    i_data_net = mk_flit(8'hD1, 2'd0, 2'd0, 2'd1, 2'd2);
    rx_exp.push_back({4'b0000, 8'hD1});
    cyc();
    i_data_net = mk_flit(8'hD2, 2'd2, 2'd1, 2'd1, 2'd2);
    rx_exp.push_back({4'b1001, 8'hD2});
    cyc();
    i_data_net = mk_flit(8'hD3, 2'd3, 2'd0, 2'd1, 2'd2);
    rx_exp.push_back({4'b1100, 8'hD3});
    i_ready_nrn = 1'b1;
    i_data_nrn = 8'h77;
    i_valid_nrn = 1'b1;
    push_result(8'h77);
    cyc();
    i_ready_nrn = 1'b0;
    i_valid_nrn = 1'b0;
    check("sim_busy", {31'd0, o_busy}, 32'd1);
    check("sim_ready_net", {31'd0, o_ready_net}, 32'd1);
    i_data_net = mk_flit(8'hD4, 2'd1, 2'd1, 2'd1, 2'd2);
    rx_exp.push_back({4'b0101, 8'hD4});
    cyc();
    check("sim_count3", {31'd0, o_ready_net}, 32'd1);
    i_data_net = mk_flit(8'hD5, 2'd0, 2'd3, 2'd1, 2'd2);
    rx_exp.push_back({4'b0011, 8'hD5});
    cyc();
    i_valid_net = 1'b0;
    check("sim_count4_full", {31'd0, o_ready_net}, 32'd0);
    i_ready_nrn = 1'b1;
    repeat (5) cyc();
    i_ready_nrn = 1'b0;
    wait_tx_done("sim_tx_done");
    check("sim_rx_queue", 32'(rx_exp.size()), 32'd0);
    check("sim_tx_queue", 32'(tx_exp.size()), 32'd0);

    // Reset mid-SEND, then restart from entry 0.
    i_ready_net = 1'b0;
    i_data_nrn = 8'h99;
    i_valid_nrn = 1'b1;
    tx_exp.push_back(mk_flit(8'h99, 2'd1, 2'd2, 2'd2, 2'd2));
    cyc();
    i_valid_nrn = 1'b0;
    repeat (3) cyc();
    #2;
    rstn = 1'b0;
    #1;
    check("mid_rst_valid_net", {31'd0, o_valid_net}, 32'd0);
    check("mid_rst_data_net", 32'(o_data_net), 32'd0);
    check("mid_rst_busy", {31'd0, o_busy}, 32'd0);
    check("mid_rst_ready_nrn", {31'd0, o_ready_nrn}, 32'd1);
    check("mid_rst_drop", 32'(o_drop_cnt), 32'd0);
    tx_exp.delete();
    cyc();
    rstn = 1'b1;
    cyc();
    i_ready_net = 1'b1;
    i_data_nrn = 8'h42;
    i_valid_nrn = 1'b1;
    push_result(8'h42);
    cyc();
    i_valid_nrn = 1'b0;
    wait_tx_done("restart_tx_done");
    check("restart_queue", 32'(tx_exp.size()), 32'd0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pe_net_iface.md
# pe_net_iface

PE-side network interface for the bufferless XY mesh: the endpoint on the far side of a switch's PE port. Receive path accepts flits ejected by the local switch, checks the destination, buffers payload plus source in a small FIFO and hands it to the neuron with valid/ready. Transmit path takes one neuron result and injects it as a sequence of unicast flits, one per entry of a static destination list, honouring the switch's injection backpressure.

## Interface
Parameters:
- x_coord, 'd1, own mesh X coordinate
- y_coord, 'd2, own mesh Y coordinate
- x_size, 2, bits per X coordinate
- y_size, 2, bits per Y coordinate
- data_width, 8, payload bits
- total_width, 2*x_size+2*y_size+data_width, flit width
- num_dest, 4, destinations per result (1..16)
- dest_list, 0, packed num_dest*(x_size+y_size) bits; entry i at [i*(x_size+y_size) +: x_size+y_size] = {dst_x, dst_y}
- fifo_depth, 4, receive FIFO entries (power of 2, ≥2)

Ports (reset is asynchronous, active-low; one clock):
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- i_valid_net  in  1  flit from switch valid (switch o_valid_pe)
- i_data_net  in  total_width  flit from switch
- o_ready_net  out  1  this block can accept a flit (to switch i_ready_pe)
- o_valid_net  out  1  injected flit valid (to switch i_valid_pe)
- o_data_net  out  total_width  injected flit
- i_ready_net  in  1  switch accepts injection (switch o_ready_pe)
- o_valid_nrn  out  1  received payload available to neuron
- o_data_nrn  out  data_width  received payload
- o_src_nrn  out  x_size+y_size  {src_x, src_y} of received payload
- i_ready_nrn  in  1  neuron consumes head payload
- i_valid_nrn  in  1  neuron result valid
- i_data_nrn  in  data_width  neuron result
- o_ready_nrn  out  1  block can take a new result
- o_busy  out  1  transmit sequence in progress
- o_drop_cnt  out  8  misaddressed flits dropped, saturating

## Operation
- Flit layout, LSB first: [y_size-1:0] dst_y, next x_size dst_x, next y_size src_y, next x_size src_x, top data_width data.
- Receive: transfer when i_valid_net & o_ready_net at posedge. o_ready_net = ~fifo_full (from registered count). Held valid across cycles with ready high counts as one flit per cycle.
- Dst == {x_coord, y_coord}: push {src, data}. Otherwise: accept, discard, increment o_drop_cnt (stops at 255).
- FIFO first-word-fall-through: o_valid_nrn = ~empty; o_data_nrn/o_src_nrn = head. Pop on o_valid_nrn & i_ready_nrn. Push and pop same cycle: count unchanged, both succeed. Pointers wrap modulo fifo_depth.
- Transmit FSM, states IDLE, SEND.
  - IDLE: o_ready_nrn=1, o_valid_net=0. On i_valid_nrn: capture i_data_nrn, idx=0, load o_data_net = {data, x_coord, y_coord, dest_list[0]}, go SEND.
  - SEND: o_ready_nrn=0, o_valid_net=1, o_busy=1. On i_ready_net: if idx==num_dest-1 → IDLE (o_valid_net low next cycle); else idx+1, o_data_net reloads with next entry, stay SEND. No ready: hold data and valid unchanged.
  - Self-addressed entries are injected normally.
- Receive and transmit paths are independent; both may transfer in the same cycle.

## Timing
- Reset (async assert, any time including mid-sequence): o_valid_net=0, o_data_net=0, o_valid_nrn=0, FIFO empty, o_ready_net=1, o_ready_nrn=1, o_busy=0, o_drop_cnt=0, FSM IDLE, idx=0; in-flight result discarded.
- Receive latency: flit accepted at edge N → o_valid_nrn high after edge N.
- o_ready_net falls the cycle after the push filling the FIFO; rises the cycle after the freeing pop.
- Transmit: result captured at edge N → first flit valid after edge N; with i_ready_net held high, flit k transfers at edge N+1+k; o_ready_nrn high again after edge N+num_dest.
- i_ready_net is combinational from the switch; block samples it only at posedge; o_valid_net never depends combinationally on it.

## Test plan
- Reset then idle: all outputs at reset values; assert rstn low mid-SEND → o_valid_net drops immediately, next result restarts at entry 0.
- Inject flit dst=(1,2) src=(0,2) data=8'hA5, i_ready_nrn=0 → o_valid_nrn=1, o_data_nrn=8'hA5, o_src_nrn=4'b0010; 4 more flits → fourth stored, o_ready_net=0, fifth held until a pop.
- Flit dst=(3,3) → not stored, o_drop_cnt=1; 300 such flits → o_drop_cnt=255.
- Result 8'h3C, dest_list {(2,2),(3,2),(1,3),(1,2)}, i_ready_net=1 → four consecutive flits with dst in that order, src=(1,2), data 8'h3C; o_ready_nrn low 4 cycles.
- Same with i_ready_net toggling 1,0,0,1,... → each flit held stable while ready low; no duplicate or skipped destination.
- Simultaneous push and pop at count 2 plus injection running → count stays 2, FIFO order preserved, transmit unaffected.
